unsigned_seq_div_rs: RTL
========================

Name: unsigned_seq_div_RS

Overview:
- Sequential unsigned restoring divider; the inverse datapath of the team's unsigned sequential left-shift multiplier.
- Divides a 2W-bit dividend by a W-bit divisor to give a W-bit quotient and a W-bit remainder, one quotient bit per clock.
- Used to check and undo multiplier results: a product from the multiplier divided by one factor returns the other factor with remainder 0.
- Same load/hold operand style as the multiplier.

Parameters:
- WIDTH, 6, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
- system_clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of system_clk.
- load  in  1  start request; dividend and divisor captured when sampled high in IDLE or DONE.
- dividend  in  2*WIDTH  unsigned dividend.
- divisor  in  WIDTH  unsigned divisor.
- quotient  out  WIDTH  result quotient, held until next accepted load.
- remainder  out  WIDTH  result remainder, held until next accepted load.
- busy  out  1  high while in RUN.
- done  out  1  level; high in DONE until next accepted load.
- div_by_zero  out  1  result flag: divisor was 0.
- overflow  out  1  result flag: quotient does not fit in WIDTH bits.

Behaviour:
- Reset (rst=0 at edge): state=IDLE; quotient, remainder, busy, done, div_by_zero and overflow all 0; internal A, Q and step counter cleared. Reset mid-RUN aborts with no partial result visible.
- States: IDLE, RUN, DONE.
- IDLE/DONE with load=1 at edge: clear done and both flags, then classify the operands:
  - divisor==0: go to DONE; div_by_zero=1; quotient=all ones; remainder=dividend[WIDTH-1:0].
  - else if dividend[2W-1:W] >= divisor: go to DONE; overflow=1; quotient=all ones; remainder=0.
  - else: A (WIDTH+1 bits)={0,dividend[2W-1:W]}; Q=dividend[W-1:0]; step=0; go to RUN. quotient/remainder keep old values until DONE.
- RUN, each edge:
  - Shift {A,Q} left by 1; the MSB of Q enters the LSB of A.
  - Trial T = A_shifted - {0,divisor}.
  - If T is non-negative: A=T and Q[0]=1; else keep A_shifted and Q[0]=0.
  - step++.
  - On the WIDTH-th step: quotient=Q_new, remainder=A_new[W-1:0], go to DONE, done=1.
- Latency:
  - Normal: done is visible after the WIDTH-th edge following the load edge (6 cycles at default).
  - Special cases: done is visible right after the load edge.
- load in RUN is ignored; the operation continues unchanged.
- load held high in DONE restarts every cycle; each accepted load starts a fresh operation.
- Operands need to be stable only at the accepting edge.
- Invariant (non-error results): dividend == quotient*divisor + remainder, with remainder < divisor.
- rst has priority over load.

Optional Feature:
- Macro DIV_DEBUG_EN.
- Defined: three extra outputs are added:
  - X (WIDTH+1 bits) = live partial remainder A.
  - Y (WIDTH bits) = live Q register.
  - step_cnt = current step.
  - All three are 0 after reset and update every RUN cycle, mirroring the multiplier's X/Y observation ports.
- Undefined: these ports and their logic are absent; functional behaviour is identical.

Test Plan:
- rst=0 for 2 edges, then 1 -> all outputs 0, state IDLE; dividend=260, divisor=20, load pulse -> busy for 6 cycles, then done=1, quotient=13, remainder=0.
- dividend=288, divisor=24 -> quotient=12, remainder=0; then dividend=100, divisor=7 -> quotient=14, remainder=2; done stays high until next load.
- divisor=0, dividend=45 -> done one edge after load, div_by_zero=1, quotient=63, remainder=45, overflow=0.
- dividend=4000, divisor=20 (upper half 62>=20) -> done one edge after load, overflow=1, quotient=63, remainder=0; next valid load clears overflow.
- Start 260/20; at step 3, pulse load with 100/7 -> ignored, result 13 r0. Restart and drive rst=0 at step 3 -> busy=0, done=0, outputs 0; next load completes normally.
- Random sweep of 500 non-error pairs -> quotient*divisor+remainder==dividend and remainder<divisor every time.

Source files
------------

// File: rtl/unsigned_seq_div_rs.sv
// Sequential unsigned restoring divider: a 2*WIDTH-bit dividend divided by a
// WIDTH-bit divisor, one quotient bit per clock. Define DIV_DEBUG_EN to expose X/Y/step_cnt.
module unsigned_seq_div_rs #(
  parameter int WIDTH = 6
) (
  input  logic                 system_clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic                 overflow
`ifdef DIV_DEBUG_EN
  ,
  output logic [WIDTH:0]       X,
  output logic [WIDTH-1:0]     Y,
  output logic [$clog2(WIDTH+1)-1:0] step_cnt
`endif
);

  localparam int SW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH:0]  a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [SW-1:0]   step;
  logic [WIDTH:0]  a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] upper;

  // One restoring iteration: shift {A,Q}, trial-subtract, keep or restore.
  function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   a,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   a_sh;
    logic [WIDTH+1:0] diff;
    a_sh = {a[WIDTH-1:0], q[WIDTH-1]};
    diff = {1'b0, a_sh} - {2'b00, d};
    if (diff[WIDTH+1]) return {a_sh, q[WIDTH-2:0], 1'b0};
    else               return {diff[WIDTH:0], q[WIDTH-2:0], 1'b1};
  endfunction

  assign upper          = dividend[2*WIDTH-1:WIDTH];
  assign {a_nxt, q_nxt} = div_step(a_q, q_q, d_q);

  always_ff @(posedge system_clk) begin
    if (!rst) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      step        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
            end else if (upper >= divisor) begin
              // Quotient would need more than WIDTH bits: saturate.
              state     <= DONE;
              done      <= 1'b1;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              a_q   <= {1'b0, upper};
              q_q   <= dividend[WIDTH-1:0];
              d_q   <= divisor;
              step  <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          a_q  <= a_nxt;
          q_q  <= q_nxt;
          step <= step + SW'(1);
          if (step == SW'(WIDTH - 1)) begin
            quotient  <= q_nxt;
            remainder <= a_nxt[WIDTH-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_DEBUG_EN
  assign X        = a_q;
  assign Y        = q_q;
  assign step_cnt = step;
`endif

endmodule
